// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding, counter-width helper and round-robin picker for mul_seq_arbiter
package mul_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  function automatic logic [15:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int n);
    logic [15:0] g;
    logic found;
    logic [3:0] k;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      k = 4'((int'(ptr) + i) % n);
      if (i < n && !found && valid[k]) begin
        g[k] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/shift_add_mul_core.sv
// shift_add_mul_core: one partial product per step; ports clk/rst, load/step control, a_in/b_in operands, acc result, b_zero (b empty after this step), last_step (counter at W-1)
module shift_add_mul_core import mul_seq_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] acc,
  output logic         b_zero,
  output logic         last_step
);
  localparam int CNT_W = cnt_w(W);
  logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    a_d = load ? a_in : step ? a_q << 1 : a_q;
    b_d = load ? b_in : step ? b_q >> 1 : b_q;
    acc_d = load ? '0 : (step && b_q[0]) ? acc_q + a_q : acc_q;
    cnt_d = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign acc = acc_q;
  assign b_zero = ~|b_q[W-1:1];
  assign last_step = cnt_q == CNT_W'(W - 1);
endmodule

// File: rtl/mul_seq_arbiter.sv
// mul_seq_arbiter: round-robin shares one serial multiplier among N requesters (req_valid/req_ready/req_a/req_b in, rsp_valid/rsp_ready/rsp_result/rsp_id out, busy); MUL_EARLY_TERM_EN ends RUN once b is exhausted
module mul_seq_arbiter import mul_seq_pkg::*; #(
  parameter int N = 4,
  parameter int W = 32,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_result,
  output logic [IDW-1:0] rsp_id,
  output logic           busy
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gidx;
  logic [W-1:0] result_q, result_d, acc, a_sel, b_sel;
  logic rsp_valid_q, rsp_valid_d, accept, step, run_exit, b_zero, last_step;
  logic [N-1:0] grant;
  shift_add_mul_core #(.W(W)) u_core (
    .clk(clk), .rst(rst), .load(accept), .step(step), .a_in(a_sel), .b_in(b_sel),
    .acc(acc), .b_zero(b_zero), .last_step(last_step)
  );
  always_comb begin
    grant = (state_q == IDLE && !rst) ? N'(rr_pick(16'(req_valid), 4'(ptr_q), N)) : '0;
    gidx = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx = IDW'(i);
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
    accept = |grant;
    step = state_q == RUN;
`ifdef MUL_EARLY_TERM_EN
    run_exit = b_zero | last_step;
`else
    // b is always drained by the final count, so this reduces to last_step
    run_exit = b_zero & last_step;
`endif
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    result_d = result_q;
    rsp_valid_d = rsp_valid_q;
    if (accept) begin
      state_d = RUN;
      id_d = gidx;
      ptr_d = (gidx == IDW'(N - 1)) ? '0 : gidx + 1'b1;
    end
    if (step && run_exit) state_d = DONE;
    // first DONE cycle captures the settled accumulator into the response register
    if (state_q == DONE && !rsp_valid_q) begin
      rsp_valid_d = 1'b1;
      result_d = acc;
    end
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      result_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      result_q <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_id = id_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/mul_seq_arbiter.md
Name: mul_seq_arbiter

Overview:
- Shares one serial shift-add multiplier datapath between N requesters. The datapath computes one partial-product bit per clock.
- Round-robin arbitration selects a requester, then the block sequences the W-cycle multiply and returns the result with the requester ID on a single valid/ready response channel.
- Sits between DPI/driver-facing request ports and the multiplier core.

Parameters:
- N, 4, number of requesters (2..16)
- W, 32, operand and result width in bits

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester grant, one-hot or zero
- req_a  in  N*W  multiplicands, requester i at bits [i*W +: W]
- req_b  in  N*W  multipliers, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_result  out  W  product modulo 2^W
- rsp_id  out  $clog2(N)  index of the requester that owns the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0, state=IDLE, RR pointer=0, accumulator/shift registers=0.
- Reset asserted mid-operation aborts immediately. No response is issued for the aborted request.
- States:
  - IDLE: if any req_valid, go to RUN.
  - RUN: step counter 0..W-1. Go to DONE when the counter reaches W-1.
  - DONE: hold the response until rsp_ready, then go to IDLE.
- Arbitration (IDLE only):
  - req_ready is combinational. It is the first set req_valid found searching from the RR pointer upward, wrapping modulo N.
  - req_ready is zero in RUN and DONE.
- Accept:
  - A handshake at edge t latches a=req_a[i], b=req_b[i] and id=i, and clears acc.
  - RR pointer becomes (i+1) mod N.
- RUN step, each cycle:
  - if b[0], acc += a (W-bit, wraps);
  - a <<= 1; b >>= 1 (logical).
- Latency: rsp_valid rises at edge t+W+1 (W RUN cycles plus the DONE entry).
- Response:
  - rsp_result, rsp_id and rsp_valid stay stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid=0 at the next edge and the state returns to IDLE.
  - One idle bubble follows each response: no grant in the DONE→IDLE cycle.
- Requester rules:
  - req_valid must not drop, and req_a/req_b must not change, before req_ready.
  - The bench asserts this; the block does not check it.
- Arithmetic: the result is the low W bits of a*b, unsigned. Overflow is silently discarded.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN
- Defined:
  - RUN exits to DONE after the step in which the remaining b (after shift) becomes zero.
  - RUN cycles = max(1, msb_index(b)+1), so b=0 takes 1 cycle.
  - Latency = RUN cycles + 1.
  - The result is identical to the full run.
- Undefined: RUN is always exactly W cycles.

Decomposition:
- Package mul_seq_pkg:
  - state enum (IDLE, RUN, DONE);
  - CNT_W = $clog2(W) localparam helper;
  - function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module shift_add_mul_core: holds a/b/acc and the step counter.
  - Inputs: load, step, a_in, b_in.
  - Outputs: acc, b_zero, last_step.
- The top level holds the FSM, RR pointer, ID register and response register.

Test Plan (N=4, W=32 unless noted):
- Single request: req0 a=3, b=5 accepted at cycle t → rsp_valid at t+33, rsp_result=15, rsp_id=0; busy high from t+1 to the handshake.
- Contention: req_valid=4'b1111 held from reset, rsp_ready=1 → grants in order 0,1,2,3,0; each grant one bubble after the prior response.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid with a=7, b=6 → rsp_result=42 and rsp_id stable for all 10 cycles; req_ready stays 0; accepted on the cycle rsp_ready=1.
- Overflow: a=0xFFFFFFFF, b=2 → rsp_result=0xFFFFFFFE.
- Reset mid-RUN: rst pulsed at the 10th RUN cycle → all outputs 0 immediately; the next request from req2 is granted with pointer=0 priority order, and its result is correct.
- MUL_EARLY_TERM_EN defined: a=9, b=5 → 3 RUN cycles, rsp_valid at t+4, rsp_result=45; b=0 → rsp_valid at t+2, rsp_result=0.
